// File: rtl/memory_pipe_arbiter_nch.sv
// N-channel memory pipe arbiter: grants one of P_CH core requests onto a registered
// memory request port and routes in-order responses back through a channel-ID FIFO.
module memory_pipe_arbiter_nch #(
    parameter int P_CH       = 4,
    parameter int P_QDEPTH   = 16,
    parameter int P_QDEPTH_N = 4,
    parameter int P_RR       = 1
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iFLUSH,
    input  logic [P_CH-1:0]      iCH_REQ,
    output logic [P_CH-1:0]      oCH_LOCK,
    input  logic [2*P_CH-1:0]    iCH_ORDER,
    input  logic [P_CH-1:0]      iCH_RW,
    input  logic [2*P_CH-1:0]    iCH_MMUMOD,
    input  logic [32*P_CH-1:0]   iCH_PDT,
    input  logic [32*P_CH-1:0]   iCH_ADDR,
    input  logic [32*P_CH-1:0]   iCH_DATA,
    output logic [P_CH-1:0]      oCH_VALID,
    input  logic [P_CH-1:0]      iCH_BUSY,
    output logic                 oCH_PAGEFAULT,
    output logic                 oCH_QUEUE_FLUSH,
    output logic                 oCH_STORE_ACK,
    output logic [63:0]          oCH_DATA,
    output logic [27:0]          oCH_MMU_FLAGS,
    output logic                 oMEMORY_REQ,
    input  logic                 iMEMORY_LOCK,
    output logic                 oMEMORY_DATA_STORE_ACK,
    output logic [1:0]           oMEMORY_MMU_MODE,
    output logic [31:0]          oMEMORY_PDT,
    output logic [1:0]           oMEMORY_ORDER,
    output logic                 oMEMORY_RW,
    output logic [31:0]          oMEMORY_ADDR,
    output logic [31:0]          oMEMORY_DATA,
    input  logic                 iMEMORY_VALID,
    input  logic                 iMEMORY_STORE_ACK,
    input  logic                 iMEMORY_PAGE_FAULT,
    input  logic                 iMEMORY_QUEUE_FLUSH,
    input  logic [63:0]          iMEMORY_DATA,
    input  logic [27:0]          iMEMORY_MMU_FLAGS,
    output logic                 oMEMORY_BUSY,
    output logic                 oERR_ORPHAN
);
    localparam int CHW = (P_CH > 1) ? $clog2(P_CH) : 1;

    typedef struct packed {
        logic        req;
        logic        store_ack;
        logic [1:0]  mmu_mode;
        logic [31:0] pdt;
        logic [1:0]  order;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [P_CH-1:0] valid;
        logic            pagefault;
        logic            queue_flush;
        logic            store_ack;
        logic [63:0]     data;
        logic [27:0]     flags;
    } resp_t;

    mem_req_t              mem_q, mem_d;
    resp_t                 resp_q, resp_d;
    logic [CHW-1:0]        fifo_ch_q [P_QDEPTH];
    logic                  fifo_st_q [P_QDEPTH];
    logic [P_QDEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [P_QDEPTH_N:0]   count_q, count_d;
    logic [CHW-1:0]        rr_ptr_q, rr_ptr_d, rr_base;
    logic                  orphan_q, orphan_d;

    logic                  fifo_full, fifo_empty, common_lock;
    logic                  gnt_any, issue, push, pop, accept;
    logic [CHW-1:0]        gnt_idx, head_ch;
    logic [CHW:0]          idx_sum;
    logic [P_CH-1:0]       gnt_vec;
    logic                  head_st;

    assign fifo_full   = (count_q == (P_QDEPTH_N+1)'(P_QDEPTH));
    assign fifo_empty  = (count_q == '0);
    assign common_lock = fifo_full || iMEMORY_LOCK;
    assign rr_base     = (P_RR != 0) ? rr_ptr_q : '0;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx_sum = '0;
        // Scan downward so the candidate closest to the search base is written last and wins.
        for (int k = P_CH - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_base} + (CHW+1)'(k);
            if (idx_sum >= (CHW+1)'(P_CH)) idx_sum = idx_sum - (CHW+1)'(P_CH);
            if (iCH_REQ[idx_sum[CHW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_sum[CHW-1:0];
            end
        end
    end

    assign gnt_vec      = gnt_any ? (P_CH'(1) << gnt_idx) : '0;
    assign oCH_LOCK     = {P_CH{common_lock}} | (iCH_REQ & ~gnt_vec);
    assign issue        = !common_lock && gnt_any;
    assign push         = issue && !iFLUSH;
    assign head_ch      = fifo_ch_q[rd_ptr_q];
    assign head_st      = fifo_st_q[rd_ptr_q];
    assign oMEMORY_BUSY = !fifo_empty && iCH_BUSY[head_ch];
    assign accept       = iMEMORY_VALID && !oMEMORY_BUSY;
    assign pop          = accept && !fifo_empty && !iFLUSH;

    always_comb begin
        mem_d    = mem_q;
        rr_ptr_d = rr_ptr_q;
        if (!common_lock) begin
            mem_d.req = gnt_any;
            if (gnt_any) begin
                mem_d.store_ack = iCH_RW[gnt_idx];
                mem_d.rw        = iCH_RW[gnt_idx];
                mem_d.mmu_mode  = iCH_MMUMOD[2*gnt_idx +: 2];
                mem_d.order     = iCH_ORDER[2*gnt_idx +: 2];
                mem_d.pdt       = iCH_PDT[32*gnt_idx +: 32];
                mem_d.addr      = iCH_ADDR[32*gnt_idx +: 32];
                mem_d.data      = iCH_DATA[32*gnt_idx +: 32];
                if (P_RR != 0)
                    rr_ptr_d = (gnt_idx == CHW'(P_CH - 1)) ? '0 : gnt_idx + CHW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        resp_d   = resp_q;
        resp_d.valid = '0;
        orphan_d = orphan_q
                 | (accept && (fifo_empty || (head_st != iMEMORY_STORE_ACK)));
        if (iFLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + P_QDEPTH_N'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + P_QDEPTH_N'(1);
            if (push && !pop)      count_d = count_q + (P_QDEPTH_N+1)'(1);
            else if (pop && !push) count_d = count_q - (P_QDEPTH_N+1)'(1);
        end
        if (pop) begin
            resp_d.valid       = P_CH'(1) << head_ch;
            resp_d.pagefault   = iMEMORY_PAGE_FAULT;
            resp_d.queue_flush = iMEMORY_QUEUE_FLUSH;
            resp_d.store_ack   = iMEMORY_STORE_ACK;
            resp_d.data        = iMEMORY_DATA;
            resp_d.flags       = iMEMORY_MMU_FLAGS;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            mem_q    <= '0;
            resp_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            resp_q   <= resp_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end

    // NOTE: FIFO storage is not reset; entries are only read when count_q marks them valid.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            fifo_ch_q[wr_ptr_q] <= gnt_idx;
            fifo_st_q[wr_ptr_q] <= iCH_RW[gnt_idx];
        end
    end

    assign oMEMORY_REQ            = mem_q.req;
    assign oMEMORY_DATA_STORE_ACK = mem_q.store_ack;
    assign oMEMORY_MMU_MODE       = mem_q.mmu_mode;
    assign oMEMORY_PDT            = mem_q.pdt;
    assign oMEMORY_ORDER          = mem_q.order;
    assign oMEMORY_RW             = mem_q.rw;
    assign oMEMORY_ADDR           = mem_q.addr;
    assign oMEMORY_DATA           = mem_q.data;
    assign oCH_VALID              = resp_q.valid;
    assign oCH_PAGEFAULT          = resp_q.pagefault;
    assign oCH_QUEUE_FLUSH        = resp_q.queue_flush;
    assign oCH_STORE_ACK          = resp_q.store_ack;
    assign oCH_DATA               = resp_q.data;
    assign oCH_MMU_FLAGS          = resp_q.flags;
    assign oERR_ORPHAN            = orphan_q;

endmodule
